// File: rtl/ram_lsu_pkg.sv
// Shared types for the RAM load/store unit: access sizes, FSM states, lane count.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ram_lsu_pkg;

  // Access size encoding on req_size_i; 2'b11 is reserved and rejected.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  // Request sequencing states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MERGE = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4
  } state_e;

  // Byte lanes per RAM word.
  localparam int ByteLanes = 4;

endpackage

// File: rtl/ram_lsu_lane.sv
// Lane steering: extracts/extends load data and merges sub-word store data into a word.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module ram_lsu_lane
  import ram_lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  size_e       size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] merged
);

  logic [ByteLanes-1:0][7:0] lanes;
  logic [ByteLanes-1:0][7:0] merged_lanes;
  logic [7:0]                byte_sel;
  logic [15:0]               half_sel;

  assign lanes = word;

  // Select the addressed byte/half and sign- or zero-extend it to a full word.
  // A half only looks at addr_lo[1], so an odd half address lands on its aligned half.
  always_comb begin
    byte_sel = lanes[addr_lo];
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    load_val = '0;
    case (size)
      SZ_BYTE: load_val = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_HALF: load_val = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      SZ_WORD: load_val = word;
      default: load_val = '0;
    endcase
  end

  // Overlay the low bits of the store data onto the addressed lane(s) of the old word.
  // Word stores ignore the old word and the low address bits entirely.
  always_comb begin
    merged_lanes = lanes;
    case (size)
      SZ_BYTE: merged_lanes[addr_lo] = wdata[7:0];
      SZ_HALF: begin
        if (addr_lo[1]) begin
          merged_lanes[3] = wdata[15:8];
          merged_lanes[2] = wdata[7:0];
        end else begin
          merged_lanes[1] = wdata[15:8];
          merged_lanes[0] = wdata[7:0];
        end
      end
      SZ_WORD: merged_lanes = wdata;
      default: merged_lanes = lanes;
    endcase
    merged = merged_lanes;
  end

endmodule

// File: rtl/ram_lsu.sv
// Load/store initiator for a single-port word RAM (sync write, async read); sub-word stores via read-modify-write.
// Latency accept->rsp_valid_o: error 1, load 2, word store 2, byte/half store 3 cycles.
// Backpressure: req_ready_o high only in IDLE (one request in flight); no response backpressure.
// Build option: define RAM_LSU_ALIGN_CHECK_EN to reject misaligned half/word accesses instead of clearing low address bits.
module ram_lsu
  import ram_lsu_pkg::*;
#(
  parameter int  XLen      = 32,
  parameter int  NPos      = 1024,
  localparam int NPosWidth = $clog2(NPos)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [1:0]           req_size_i,
  input  logic                 req_unsigned_i,
  input  logic [XLen-1:0]      req_addr_i,
  input  logic [XLen-1:0]      req_wdata_i,
  output logic                 rsp_valid_o,
  output logic [XLen-1:0]      rsp_rdata_o,
  output logic                 rsp_err_o,
  output logic [NPosWidth-1:0] mem_a_o,
  output logic                 mem_we_o,
  output logic [XLen-1:0]      mem_wd_o,
  input  logic [XLen-1:0]      mem_rd_i
);

  state_e           state_q;
  logic             we_q;
  logic             uns_q;
  size_e            size_q;
  logic [1:0]       off_q;
  logic [XLen-1:0]  wdata_q;
  logic             mem_we_q;

  logic             size_err;
  logic             range_err;
  logic             align_err;
  logic             req_err;
  logic [XLen-1:0]  load_val;
  logic [XLen-1:0]  merged;

  assign size_err  = (req_size_i == 2'b11);
  assign range_err = |req_addr_i[XLen-1:NPosWidth+2];

`ifdef RAM_LSU_ALIGN_CHECK_EN
  assign align_err = ((req_size_i == SZ_HALF) && req_addr_i[0]) ||
                     ((req_size_i == SZ_WORD) && (req_addr_i[1:0] != 2'b00));
`else
  // Misaligned low bits are dropped by the lane logic, so nothing is rejected here.
  assign align_err = 1'b0;
`endif

  assign req_err = size_err || range_err || align_err;

  // Ready is a decode of the registered state; held low while reset is asserted.
  assign req_ready_o = (state_q == IDLE) && !rst_i;

  // The write strobe is qualified by reset so a reset cycle can never commit a write.
  assign mem_we_o = mem_we_q && !rst_i;

  ram_lsu_lane u_lane (
    .word        (mem_rd_i),
    .addr_lo     (off_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .load_val    (load_val),
    .merged      (merged)
  );

  // Request sequencer: accept, read/merge/write the RAM, then pulse the response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= SZ_BYTE;
      off_q       <= 2'b00;
      wdata_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_a_o     <= '0;
      mem_wd_o    <= '0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            we_q        <= req_we_i;
            uns_q       <= req_unsigned_i;
            size_q      <= size_e'(req_size_i);
            off_q       <= req_addr_i[1:0];
            wdata_q     <= req_wdata_i;
            mem_a_o     <= req_addr_i[NPosWidth+1:2];
            rsp_rdata_o <= '0;
            if (req_err) begin
              // Rejected requests skip the RAM entirely.
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b1;
              state_q     <= RESP;
            end else if (!req_we_i) begin
              state_q     <= LOAD;
            end else if (req_size_i == SZ_WORD) begin
              // Full-word store needs no read, go straight to the write cycle.
              mem_wd_o    <= req_wdata_i;
              mem_we_q    <= 1'b1;
              state_q     <= WRITE;
            end else begin
              state_q     <= MERGE;
            end
          end
        end
        LOAD: begin
          rsp_rdata_o <= load_val;
          rsp_valid_o <= 1'b1;
          state_q     <= RESP;
        end
        MERGE: begin
          // RAM has no byte enables: write back the old word with the new lane(s) spliced in.
          mem_wd_o <= merged;
          mem_we_q <= 1'b1;
          state_q  <= WRITE;
        end
        WRITE: begin
          mem_we_q    <= 1'b0;
          rsp_valid_o <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          rsp_valid_o <= 1'b0;
          rsp_err_o   <= 1'b0;
          rsp_rdata_o <= '0;
          state_q     <= IDLE;
        end
        default: begin
          mem_we_q    <= 1'b0;
          rsp_valid_o <= 1'b0;
          rsp_err_o   <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_lsu.sv
// Self-checking bench for ram_lsu: directed vector table, multi-cycle corner sequences, random traffic vs a request-level model.
// Latency: n/a.
// Backpressure: waits on req_ready_o with a bounded cycle budget.
module tb_ram_lsu;

  localparam int NPOS = 1024;

  logic        clk;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic [9:0]  mem_a_o;
  logic        mem_we_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram     [NPOS];
  logic [31:0] ref_mem [NPOS];
  logic        ram_fill;

  ram_lsu #(.XLen(32), .NPos(NPOS)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_rdata_o    (rsp_rdata_o),
    .rsp_err_o      (rsp_err_o),
    .mem_a_o        (mem_a_o),
    .mem_we_o       (mem_we_o),
    .mem_wd_o       (mem_wd_o),
    .mem_rd_i       (mem_rd_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h0F0F55AA;
  endfunction

  // Bench RAM: async read, sync write.
  assign mem_rd_i = ram[mem_a_o];
  always @(posedge clk) begin
    if (ram_fill) begin
      for (int i = 0; i < NPOS; i++) ram[i] <= init_word(i);
    end else if (mem_we_o) begin
      ram[mem_a_o] <= mem_wd_o;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Request-level reference: rules applied to a word array with plain arithmetic.
  task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int lat,
                       output int pulses, output logic [31:0] mwd);
    int          idx;
    int          sh;
    int          top;
    logic [31:0] w;
    logic [31:0] m;
    er = (sz == 2'b11) || (addr >= 32'(4 * NPOS));
`ifdef RAM_LSU_ALIGN_CHECK_EN
    if (sz == 2'b01 && addr[0]) er = 1'b1;
    if (sz == 2'b10 && addr[1:0] != 2'b00) er = 1'b1;
`endif
    rd = '0; pulses = 0; mwd = '0; lat = 1;
    if (!er) begin
      idx = int'(addr / 4);
      w   = ref_mem[idx];
      if (sz == 2'b00) begin sh = 8 * int'(addr % 4); m = 32'hFF << sh; top = 8; end
      else if (sz == 2'b01) begin sh = ((addr % 4) >= 2) ? 16 : 0; m = 32'hFFFF << sh; top = 16; end
      else begin sh = 0; m = 32'hFFFF_FFFF; top = 32; end
      if (!we) begin
        rd = (w & m) >> sh;
        if (!uns && top < 32 && rd[top-1]) rd = rd | ~((32'd1 << top) - 32'd1);
        lat = 2;
      end else begin
        mwd = (w & ~m) | ((wd << sh) & m);
        ref_mem[idx] = mwd;
        pulses = 1;
        lat = (sz == 2'b10) ? 2 : 3;
      end
    end
  endtask

  // Issue one request and observe it to completion (bounded).
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat,
                        output int pulses, output logic [31:0] pa, output logic [31:0] pwd);
    int w;
    rd = '0; er = 1'b0; lat = -1; pulses = 0; pa = '0; pwd = '0; w = 0;
    @(negedge clk);
    while (!req_ready_o && w < 20) begin @(negedge clk); w++; end
    req_we_i = we; req_size_i = sz; req_unsigned_i = uns;
    req_addr_i = addr; req_wdata_i = wd; req_valid_i = 1'b1;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (mem_we_o) begin pulses++; pa = 32'(mem_a_o); pwd = mem_wd_o; end
      if (rsp_valid_o) begin rd = rsp_rdata_o; er = rsp_err_o; lat = c; break; end
    end
  endtask

  task automatic run_chk(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] e_rd, input logic e_er, input int e_lat,
                         input int e_pulses, input logic [31:0] e_mwd);
    logic [31:0] rd, pa, pwd;
    logic        er;
    int          lat, pulses;
    do_req(we, sz, uns, addr, wd, rd, er, lat, pulses, pa, pwd);
    chk({tag, "/rdata"}, rd, e_rd);
    chk({tag, "/err"}, 32'(er), 32'(e_er));
    chk({tag, "/latency"}, 32'(lat), 32'(e_lat));
    chk({tag, "/we_pulses"}, 32'(pulses), 32'(e_pulses));
    if (e_pulses > 0) begin
      chk({tag, "/mem_a"}, pa, (addr >> 2) & 32'h3FF);
      chk({tag, "/mem_wd"}, pwd, e_mwd);
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] e_rd;
    logic        e_er;
    int          e_lat;
    logic [31:0] e_mwd;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] e_rd, input logic e_er, input int e_lat,
                              input logic [31:0] e_mwd);
    vec_t v;
    v.we = we; v.sz = sz; v.uns = uns; v.addr = addr; v.wd = wd;
    v.e_rd = e_rd; v.e_er = e_er; v.e_lat = e_lat; v.e_mwd = e_mwd;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] m_rd, m_wd;
    logic        m_er;
    int          m_lat, m_pl;
    logic [31:0] b2b_addr [3];
    logic [1:0]  b2b_sz   [3];
    logic        b2b_uns  [3];
    logic [31:0] b2b_exp  [3];
    int          acc_cyc  [3];
    int          rsp_cyc  [3];
    int          issued, got, cyc, npulse, nrsp, diffs;
    logic        rdy;

    // Directed vectors, expectations derived by hand.
    tbl.push_back(mk(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0, 2, 32'hDEADBEEF));
    tbl.push_back(mk(0, 2'b10, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 2, 32'h0));
    tbl.push_back(mk(1, 2'b10, 0, 32'h10, 32'h11223344, 32'h0,        0, 2, 32'h11223344));
    tbl.push_back(mk(1, 2'b00, 0, 32'h12, 32'h000000AB, 32'h0,        0, 3, 32'h11AB3344));
    tbl.push_back(mk(0, 2'b10, 0, 32'h10, 32'h0,        32'h11AB3344, 0, 2, 32'h0));
    tbl.push_back(mk(1, 2'b10, 0, 32'h20, 32'h80F07F01, 32'h0,        0, 2, 32'h80F07F01));
    tbl.push_back(mk(0, 2'b01, 0, 32'h22, 32'h0,        32'hFFFF80F0, 0, 2, 32'h0));
    tbl.push_back(mk(0, 2'b01, 1, 32'h22, 32'h0,        32'h000080F0, 0, 2, 32'h0));
    tbl.push_back(mk(0, 2'b00, 0, 32'h22, 32'h0,        32'hFFFFFFF0, 0, 2, 32'h0));
    tbl.push_back(mk(0, 2'b00, 1, 32'h21, 32'h0,        32'h0000007F, 0, 2, 32'h0));
    tbl.push_back(mk(0, 2'b00, 0, 32'h23, 32'h0,        32'hFFFFFF80, 0, 2, 32'h0));
    tbl.push_back(mk(0, 2'b01, 0, 32'h20, 32'h0,        32'h00007F01, 0, 2, 32'h0));
    tbl.push_back(mk(0, 2'b10, 0, 32'h1000, 32'h0,      32'h0,        1, 1, 32'h0));
    tbl.push_back(mk(0, 2'b11, 0, 32'h10, 32'h0,        32'h0,        1, 1, 32'h0));
    tbl.push_back(mk(1, 2'b10, 0, 32'h1000, 32'h12345678, 32'h0,      1, 1, 32'h0));
`ifdef RAM_LSU_ALIGN_CHECK_EN
    tbl.push_back(mk(0, 2'b10, 0, 32'h13, 32'h0,        32'h0,        1, 1, 32'h0));
    tbl.push_back(mk(1, 2'b01, 0, 32'h13, 32'h0000CAFE, 32'h0,        1, 1, 32'h0));
    tbl.push_back(mk(0, 2'b10, 0, 32'h10, 32'h0,        32'h11AB3344, 0, 2, 32'h0));
`else
    tbl.push_back(mk(0, 2'b10, 0, 32'h13, 32'h0,        32'h11AB3344, 0, 2, 32'h0));
    tbl.push_back(mk(1, 2'b01, 0, 32'h13, 32'h0000CAFE, 32'h0,        0, 3, 32'hCAFE3344));
    tbl.push_back(mk(0, 2'b10, 0, 32'h10, 32'h0,        32'hCAFE3344, 0, 2, 32'h0));
`endif

    for (int i = 0; i < NPOS; i++) ref_mem[i] = init_word(i);

    // Reset.
    rst_i = 1'b1; ram_fill = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0;
    req_size_i = 2'b00; req_unsigned_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset/rsp_valid", 32'(rsp_valid_o), 32'h0);
    chk("reset/rsp_rdata", rsp_rdata_o, 32'h0);
    chk("reset/rsp_err", 32'(rsp_err_o), 32'h0);
    chk("reset/mem_a", 32'(mem_a_o), 32'h0);
    chk("reset/mem_we", 32'(mem_we_o), 32'h0);
    chk("reset/mem_wd", mem_wd_o, 32'h0);
    @(posedge clk);
    #1 rst_i = 1'b0; ram_fill = 1'b0;
    @(negedge clk);
    chk("reset/ready_after_release", 32'(req_ready_o), 32'h1);

    // Directed table.
    for (int i = 0; i < tbl.size(); i++) begin
      model(tbl[i].we, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wd, m_rd, m_er, m_lat, m_pl, m_wd);
      run_chk($sformatf("vec%0d", i), tbl[i].we, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wd,
              tbl[i].e_rd, tbl[i].e_er, tbl[i].e_lat,
              (tbl[i].we && !tbl[i].e_er) ? 1 : 0, tbl[i].e_mwd);
    end

    // Back-to-back loads with valid held high.
    b2b_addr[0] = 32'h10; b2b_sz[0] = 2'b10; b2b_uns[0] = 1'b0;
    b2b_addr[1] = 32'h20; b2b_sz[1] = 2'b10; b2b_uns[1] = 1'b0;
    b2b_addr[2] = 32'h22; b2b_sz[2] = 2'b01; b2b_uns[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      model(1'b0, b2b_sz[k], b2b_uns[k], b2b_addr[k], 32'h0, b2b_exp[k], m_er, m_lat, m_pl, m_wd);
      acc_cyc[k] = -100; rsp_cyc[k] = 0;
    end
    issued = 0; got = 0; cyc = 0;
    @(negedge clk);
    req_we_i = 1'b0; req_size_i = b2b_sz[0]; req_unsigned_i = b2b_uns[0];
    req_addr_i = b2b_addr[0]; req_valid_i = 1'b1;
    while (got < 3 && cyc < 40) begin
      cyc++;
      if (rsp_valid_o) begin
        chk($sformatf("b2b%0d/rdata", got), rsp_rdata_o, b2b_exp[got]);
        rsp_cyc[got] = cyc;
        got++;
      end
      rdy = req_ready_o;
      if (rdy && issued < 3) begin acc_cyc[issued] = cyc; issued++; end
      @(posedge clk);
      #1;
      if (rdy) begin
        if (issued < 3) begin
          req_size_i = b2b_sz[issued]; req_unsigned_i = b2b_uns[issued]; req_addr_i = b2b_addr[issued];
        end else begin
          req_valid_i = 1'b0;
        end
      end
      @(negedge clk);
    end
    req_valid_i = 1'b0;
    chk("b2b/responses", 32'(got), 32'd3);
    chk("b2b/accept_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
    chk("b2b/accept_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
    for (int k = 0; k < 3; k++)
      chk($sformatf("b2b%0d/latency", k), 32'(rsp_cyc[k] - acc_cyc[k]), 32'd2);

    // Random traffic against the model.
    for (int n = 0; n < 150; n++) begin
      logic        r_we, r_uns;
      logic [1:0]  r_sz;
      logic [31:0] r_addr, r_wd;
      r_we   = 1'($urandom_range(0, 1));
      r_uns  = 1'($urandom_range(0, 1));
      r_sz   = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      r_addr = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) r_addr = r_addr | (32'h1 << $urandom_range(12, 31));
      r_wd   = $urandom;
      model(r_we, r_sz, r_uns, r_addr, r_wd, m_rd, m_er, m_lat, m_pl, m_wd);
      run_chk($sformatf("rnd%0d", n), r_we, r_sz, r_uns, r_addr, r_wd, m_rd, m_er, m_lat, m_pl, m_wd);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset during MERGE of a byte store: request dropped, nothing written.
    @(negedge clk);
    req_we_i = 1'b1; req_size_i = 2'b00; req_unsigned_i = 1'b0;
    req_addr_i = 32'h31; req_wdata_i = 32'h00000077; req_valid_i = 1'b1;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    npulse = 0; nrsp = 0;
    @(negedge clk);
    if (mem_we_o) npulse++;
    if (rsp_valid_o) nrsp++;
    rst_i = 1'b1;
    @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("rst_merge/ready_after_release", 32'(req_ready_o), 32'h1);
    for (int c = 0; c < 6; c++) begin
      if (mem_we_o) npulse++;
      if (rsp_valid_o) nrsp++;
      @(negedge clk);
    end
    chk("rst_merge/we_pulses", 32'(npulse), 32'h0);
    chk("rst_merge/rsp_pulses", 32'(nrsp), 32'h0);
    chk("rst_merge/ram_word", ram[12], ref_mem[12]);

    // Reset during WRITE of a word store: the strobe must drop and the RAM stay intact.
    req_we_i = 1'b1; req_size_i = 2'b10; req_addr_i = 32'h34; req_wdata_i = 32'hFFFF0000;
    req_valid_i = 1'b1;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    @(negedge clk);
    chk("rst_write/we_before_reset", 32'(mem_we_o), 32'h1);
    rst_i = 1'b1;
    #1;
    chk("rst_write/we_gated", 32'(mem_we_o), 32'h0);
    @(posedge clk);
    #1 rst_i = 1'b0;
    nrsp = 0;
    @(negedge clk);
    chk("rst_write/ready_after_release", 32'(req_ready_o), 32'h1);
    for (int c = 0; c < 5; c++) begin
      if (rsp_valid_o) nrsp++;
      @(negedge clk);
    end
    chk("rst_write/rsp_pulses", 32'(nrsp), 32'h0);
    chk("rst_write/ram_word", ram[13], ref_mem[13]);

    // Whole-RAM comparison against the model.
    diffs = 0;
    for (int i = 0; i < NPOS; i++) if (ram[i] !== ref_mem[i]) diffs++;
    chk("ram_contents/diff_words", 32'(diffs), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
